// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bundle between the IF-stage next-PC control and the program counter.
//
// Parameters:
//   XLEN   PC width in bits
//   CNT_W  width of the advance counter
//
// Signals (direction seen from the sequencer, i.e. the slave side):
//   Stall          in   hold PC (hazard unit)
//   branch_taken   in   EX-stage redirect request
//   branch_target  in   redirect address
//   trap_req       in   watchdog/exception redirect, overrides Stall
//   PC_Value       out  current fetch PC
//   PC_Plus4       out  PC_Value + 4, modulo 2^XLEN
//   halted         out  high while the sequencer sits at the program limit
//   redirect       out  one-cycle pulse after a non-sequential load
//   adv_cnt        out  saturating count of PC loads since reset
//   misalign_err   out  only when PC_ALIGN_CHECK_EN is defined
//
// Optional feature macro: PC_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             Stall;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
    logic             trap_req;
    logic [XLEN-1:0]  PC_Value;
    logic [XLEN-1:0]  PC_Plus4;
    logic             halted;
    logic             redirect;
    logic [CNT_W-1:0] adv_cnt;
`ifdef PC_ALIGN_CHECK_EN
    logic             misalign_err;

    modport master (
        output Stall, branch_taken, branch_target, trap_req,
        input  PC_Value, PC_Plus4, halted, redirect, adv_cnt, misalign_err
    );

    modport slave (
        input  Stall, branch_taken, branch_target, trap_req,
        output PC_Value, PC_Plus4, halted, redirect, adv_cnt, misalign_err
    );
`else
    modport master (
        output Stall, branch_taken, branch_target, trap_req,
        input  PC_Value, PC_Plus4, halted, redirect, adv_cnt
    );

    modport slave (
        input  Stall, branch_taken, branch_target, trap_req,
        output PC_Value, PC_Plus4, halted, redirect, adv_cnt
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program counter for the RV32I fetch stage. Holds the fetch PC, advances it
// by 4, redirects on branch/jump or trap, and parks in HALTED at PROG_LIMIT
// until a trap or reset. Also keeps a saturating count of PC loads for the
// watchdog and debug logic.
//
// Parameters:
//   XLEN        PC width in bits (>= 8)
//   RESET_VEC   PC value after reset
//   PROG_LIMIT  first address past the program; reaching it halts
//   TRAP_VEC    PC loaded on trap_req
//   CNT_W       width of the advance counter
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active-high, wins over everything
//   pc_bus  pc_sequencer_if slave modport (see interface header)
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   Defined     : misaligned taken branches are refused and flagged on
//                 misalign_err for one cycle.
//   Not defined : branch_target[1:0] is forced to 2'b00 before use.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter logic [XLEN-1:0] PROG_LIMIT = XLEN'(348),
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'('h100),
    parameter int unsigned     CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave pc_bus
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  w_pc_nxt;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_cand;
    logic             r_redirect;
    logic             w_redirect_nxt;
    logic             w_load;
    logic [CNT_W-1:0] r_adv_cnt;
`ifdef PC_ALIGN_CHECK_EN
    logic             r_misalign;
    logic             w_misalign_nxt;
`endif

    // Sequential successor wraps naturally at 2^XLEN.
    assign w_pc_plus4 = r_pc + XLEN'(4);

`ifdef PC_ALIGN_CHECK_EN
    assign w_target = pc_bus.branch_target;
`else
    // Low two bits are dropped so an odd target still lands on a word.
    assign w_target = pc_bus.branch_target & ~XLEN'(3);
`endif

    // Candidate for a non-trap, non-stalled update in RUN.
    assign w_cand = pc_bus.branch_taken ? w_target : w_pc_plus4;

    // -------------------------------------------------------------------------
    // Next-state / next-PC logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_redirect_nxt = 1'b0;
        w_load         = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        w_misalign_nxt = 1'b0;
`endif
        case (r_state)
            ST_RUN: begin
                if (pc_bus.trap_req) begin
                    // Trap overrides Stall and any pending branch.
                    w_pc_nxt       = TRAP_VEC;
                    w_redirect_nxt = 1'b1;
                    w_load         = 1'b1;
                end else if (!pc_bus.Stall) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (pc_bus.branch_taken && (w_target[1:0] != 2'b00)) begin
                        w_misalign_nxt = 1'b1;
                    end else
`endif
                    begin
                        w_load = 1'b1;
                        if (w_cand >= PROG_LIMIT) begin
                            // Clamp to the limit; this load is not a redirect.
                            w_pc_nxt    = PROG_LIMIT;
                            w_state_nxt = ST_HALTED;
                        end else begin
                            w_pc_nxt       = w_cand;
                            w_redirect_nxt = pc_bus.branch_taken;
                        end
                    end
                end
            end
            ST_HALTED: begin
                // Only a trap (or reset) leaves HALTED.
                if (pc_bus.trap_req) begin
                    w_pc_nxt       = TRAP_VEC;
                    w_state_nxt    = ST_RUN;
                    w_redirect_nxt = 1'b1;
                    w_load         = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_VEC;
            r_redirect <= 1'b0;
            r_adv_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_redirect <= w_redirect_nxt;
            // Saturate instead of wrapping so the watchdog never sees a reset count.
            if (w_load && (r_adv_cnt != {CNT_W{1'b1}})) begin
                r_adv_cnt <= r_adv_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end

    assign pc_bus.misalign_err = r_misalign;
`endif

    assign pc_bus.PC_Value = r_pc;
    assign pc_bus.PC_Plus4 = w_pc_plus4;
    assign pc_bus.halted   = (r_state == ST_HALTED);
    assign pc_bus.redirect = r_redirect;
    assign pc_bus.adv_cnt  = r_adv_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed scenarios plus randomized traffic against a behavioural model of
// the program counter. A second instance with CNT_W=2 shares the inputs to
// exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] LIMIT = 32'd348;
    localparam logic [31:0] TVEC  = 32'h100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32), .CNT_W(16)) bus ();
    pc_sequencer_if #(.XLEN(32), .CNT_W(2))  bus2 ();

    assign bus2.Stall         = bus.Stall;
    assign bus2.branch_taken  = bus.branch_taken;
    assign bus2.branch_target = bus.branch_target;
    assign bus2.trap_req      = bus.trap_req;

    pc_sequencer #(.XLEN(32), .CNT_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .pc_bus (bus)
    );

    pc_sequencer #(.XLEN(32), .CNT_W(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .pc_bus (bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_red;
    bit          m_mis;
    int unsigned m_cnt;
    int unsigned m_cnt2;

    task automatic model_edge(input bit r, input bit st, input bit br,
                              input logic [31:0] tgt, input bit tr);
        bit          loaded;
        logic [31:0] cand;
        loaded = 0;
        m_red  = 0;
        m_mis  = 0;
        if (r) begin
            m_pc = 0; m_halted = 0; m_cnt = 0; m_cnt2 = 0;
            return;
        end
        if (tr) begin
            m_pc = TVEC; m_halted = 0; m_red = 1; loaded = 1;
        end else if (!m_halted && !st) begin
`ifdef PC_ALIGN_CHECK_EN
            if (br && tgt[1:0] != 2'b00) begin
                m_mis = 1;
            end else begin
                cand = br ? tgt : m_pc + 32'd4;
`else
            begin
                cand = br ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
`endif
                loaded = 1;
                if (cand >= LIMIT) begin
                    m_pc = LIMIT; m_halted = 1;
                end else begin
                    m_pc = cand; m_red = br;
                end
            end
        end
        if (loaded) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic apply(input bit r, input bit st, input bit br,
                         input logic [31:0] tgt, input bit tr);
        rst               = r;
        bus.Stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.trap_req      = tr;
        @(posedge clk);
        model_edge(r, st, br, tgt, tr);
        #1;
    endtask

    task automatic test_reset;
        apply(1, 0, 0, 0, 0);
        apply(1, 1, 1, 32'd80, 0);
        n_checks++; if (bus.PC_Value !== 32'd0) begin n_errors++; $display("FAIL reset_pc got %0h expected 0", bus.PC_Value); end
        n_checks++; if (bus.PC_Plus4 !== 32'd4) begin n_errors++; $display("FAIL reset_plus4 got %0h expected 4", bus.PC_Plus4); end
        n_checks++; if (bus.halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted got %b expected 0", bus.halted); end
        n_checks++; if (bus.redirect !== 1'b0) begin n_errors++; $display("FAIL reset_redirect got %b expected 0", bus.redirect); end
        n_checks++; if (bus.adv_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt got %0d expected 0", bus.adv_cnt); end
        n_checks++; if (bus2.adv_cnt !== 2'd0) begin n_errors++; $display("FAIL reset_cnt2 got %0d expected 0", bus2.adv_cnt); end
    endtask

    task automatic test_sequential;
        for (int i = 1; i <= 5; i++) begin
            apply(0, 0, 0, 0, 0);
            n_checks++; if (bus.PC_Value !== 32'(4 * i)) begin n_errors++; $display("FAIL seq_pc step %0d got %0h expected %0h", i, bus.PC_Value, 4 * i); end
            n_checks++; if (bus.redirect !== 1'b0) begin n_errors++; $display("FAIL seq_redirect step %0d got %b expected 0", i, bus.redirect); end
        end
        n_checks++; if (bus.adv_cnt !== 16'd5) begin n_errors++; $display("FAIL seq_cnt got %0d expected 5", bus.adv_cnt); end
        n_checks++; if (bus2.adv_cnt !== 2'd3) begin n_errors++; $display("FAIL sat_cnt2 got %0d expected 3", bus2.adv_cnt); end
        n_checks++; if (bus.PC_Plus4 !== 32'd24) begin n_errors++; $display("FAIL seq_plus4 got %0h expected 24", bus.PC_Plus4); end
    endtask

    task automatic test_stall_branch;
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 0);
        n_checks++; if (bus.PC_Value !== 32'd40) begin n_errors++; $display("FAIL stall_pre_pc got %0d expected 40", bus.PC_Value); end
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 1, 32'd200, 0);
            n_checks++; if (bus.PC_Value !== 32'd40) begin n_errors++; $display("FAIL stall_pc cycle %0d got %0d expected 40", i, bus.PC_Value); end
            n_checks++; if (bus.redirect !== 1'b0) begin n_errors++; $display("FAIL stall_redirect cycle %0d got %b expected 0", i, bus.redirect); end
        end
        n_checks++; if (bus.adv_cnt !== 16'd10) begin n_errors++; $display("FAIL stall_cnt got %0d expected 10", bus.adv_cnt); end
        apply(0, 0, 1, 32'd200, 0);
        n_checks++; if (bus.PC_Value !== 32'd200) begin n_errors++; $display("FAIL branch_pc got %0d expected 200", bus.PC_Value); end
        n_checks++; if (bus.redirect !== 1'b1) begin n_errors++; $display("FAIL branch_redirect got %b expected 1", bus.redirect); end
        apply(0, 0, 0, 0, 0);
        n_checks++; if (bus.PC_Value !== 32'd204) begin n_errors++; $display("FAIL post_branch_pc got %0d expected 204", bus.PC_Value); end
        n_checks++; if (bus.redirect !== 1'b0) begin n_errors++; $display("FAIL redirect_pulse got %b expected 0", bus.redirect); end
    endtask

    task automatic test_halt;
        apply(0, 0, 1, 32'd344, 0);
        n_checks++; if (bus.PC_Value !== 32'd344) begin n_errors++; $display("FAIL pre_halt_pc got %0d expected 344", bus.PC_Value); end
        apply(0, 0, 0, 0, 0);
        n_checks++; if (bus.PC_Value !== LIMIT) begin n_errors++; $display("FAIL halt_pc got %0d expected 348", bus.PC_Value); end
        n_checks++; if (bus.halted !== 1'b1) begin n_errors++; $display("FAIL halt_flag got %b expected 1", bus.halted); end
        n_checks++; if (bus.redirect !== 1'b0) begin n_errors++; $display("FAIL halt_redirect got %b expected 0", bus.redirect); end
        for (int i = 0; i < 4; i++) begin
            apply(0, i[0], 1, 32'd8, 0);
            n_checks++; if (bus.PC_Value !== LIMIT || bus.halted !== 1'b1) begin n_errors++; $display("FAIL halted_hold cycle %0d got pc %0d halted %b expected 348 1", i, bus.PC_Value, bus.halted); end
        end
        n_checks++; if (bus.adv_cnt !== 16'd14) begin n_errors++; $display("FAIL halted_cnt got %0d expected 14", bus.adv_cnt); end
        apply(0, 0, 1, 32'd8, 1);
        n_checks++; if (bus.PC_Value !== TVEC) begin n_errors++; $display("FAIL trap_exit_pc got %0h expected 100", bus.PC_Value); end
        n_checks++; if (bus.halted !== 1'b0) begin n_errors++; $display("FAIL trap_exit_halted got %b expected 0", bus.halted); end
        n_checks++; if (bus.redirect !== 1'b1) begin n_errors++; $display("FAIL trap_exit_redirect got %b expected 1", bus.redirect); end
        n_checks++; if (bus.adv_cnt !== 16'd15) begin n_errors++; $display("FAIL trap_exit_cnt got %0d expected 15", bus.adv_cnt); end
    endtask

    task automatic test_trap_priority;
        apply(0, 0, 0, 0, 0);
        apply(0, 1, 1, 32'd200, 1);
        n_checks++; if (bus.PC_Value !== TVEC) begin n_errors++; $display("FAIL trap_prio_pc got %0h expected 100", bus.PC_Value); end
        n_checks++; if (bus.redirect !== 1'b1) begin n_errors++; $display("FAIL trap_prio_redirect got %b expected 1", bus.redirect); end
        apply(0, 0, 1, 32'd1000, 0);
        n_checks++; if (bus.PC_Value !== LIMIT || bus.halted !== 1'b1) begin n_errors++; $display("FAIL far_branch got pc %0d halted %b expected 348 1", bus.PC_Value, bus.halted); end
        n_checks++; if (bus.redirect !== 1'b0) begin n_errors++; $display("FAIL far_branch_redirect got %b expected 0", bus.redirect); end
        apply(0, 1, 0, 0, 1);
        n_checks++; if (bus.PC_Value !== TVEC || bus.halted !== 1'b0) begin n_errors++; $display("FAIL halted_trap_stall got pc %0h halted %b expected 100 0", bus.PC_Value, bus.halted); end
    endtask

    task automatic test_misalign;
        apply(0, 0, 1, 32'h2A, 0);
`ifdef PC_ALIGN_CHECK_EN
        n_checks++; if (bus.PC_Value !== TVEC) begin n_errors++; $display("FAIL misalign_pc got %0h expected 100", bus.PC_Value); end
        n_checks++; if (bus.misalign_err !== 1'b1) begin n_errors++; $display("FAIL misalign_flag got %b expected 1", bus.misalign_err); end
        n_checks++; if (bus.redirect !== 1'b0) begin n_errors++; $display("FAIL misalign_redirect got %b expected 0", bus.redirect); end
        apply(0, 0, 0, 0, 0);
        n_checks++; if (bus.misalign_err !== 1'b0) begin n_errors++; $display("FAIL misalign_pulse got %b expected 0", bus.misalign_err); end
`else
        n_checks++; if (bus.PC_Value !== 32'h28) begin n_errors++; $display("FAIL align_force_pc got %0h expected 28", bus.PC_Value); end
        n_checks++; if (bus.redirect !== 1'b1) begin n_errors++; $display("FAIL align_force_redirect got %b expected 1", bus.redirect); end
`endif
    endtask

    task automatic test_reset_mid_branch;
        apply(0, 0, 0, 0, 0);
        apply(1, 0, 1, 32'd80, 0);
        n_checks++; if (bus.PC_Value !== 32'd0) begin n_errors++; $display("FAIL rst_mid_pc got %0d expected 0", bus.PC_Value); end
        n_checks++; if (bus.adv_cnt !== 16'd0) begin n_errors++; $display("FAIL rst_mid_cnt got %0d expected 0", bus.adv_cnt); end
        n_checks++; if (bus.halted !== 1'b0 || bus.redirect !== 1'b0) begin n_errors++; $display("FAIL rst_mid_flags got halted %b redirect %b expected 0 0", bus.halted, bus.redirect); end
    endtask

    task automatic test_random;
        bit          r, st, br, tr;
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 3) == 0);
            tr  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 420));
            apply(r, st, br, tgt, tr);
            n_checks++; if (bus.PC_Value !== m_pc) begin n_errors++; $display("FAIL rnd_pc cycle %0d got %0h expected %0h", i, bus.PC_Value, m_pc); end
            n_checks++; if (bus.PC_Plus4 !== m_pc + 32'd4) begin n_errors++; $display("FAIL rnd_plus4 cycle %0d got %0h expected %0h", i, bus.PC_Plus4, m_pc + 32'd4); end
            n_checks++; if (bus.halted !== m_halted || bus.redirect !== m_red) begin n_errors++; $display("FAIL rnd_flags cycle %0d got halted %b redirect %b expected %b %b", i, bus.halted, bus.redirect, m_halted, m_red); end
            n_checks++; if (bus.adv_cnt !== 16'(m_cnt) || bus2.adv_cnt !== 2'(m_cnt2)) begin n_errors++; $display("FAIL rnd_cnt cycle %0d got %0d/%0d expected %0d/%0d", i, bus.adv_cnt, bus2.adv_cnt, m_cnt, m_cnt2); end
`ifdef PC_ALIGN_CHECK_EN
            n_checks++; if (bus.misalign_err !== m_mis) begin n_errors++; $display("FAIL rnd_misalign cycle %0d got %b expected %b", i, bus.misalign_err, m_mis); end
`endif
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.Stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.trap_req      = 1'b0;
        m_pc = 0; m_halted = 0; m_red = 0; m_mis = 0; m_cnt = 0; m_cnt2 = 0;

        test_reset();
        test_sequential();
        test_stall_branch();
        test_halt();
        test_trap_priority();
        test_misalign();
        test_reset_mid_branch();
        test_random();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
